// File: rtl/ili9341_frame_sched.sv
// Frame scheduler: walks the screen in raster order, pulls each pixel from a source
// over req/valid and hands it to the ILI9341 pixel driver with a hold-until-busy strobe.
module ili9341_frame_sched #(
    parameter int          H_RES       = 320,
    parameter int          V_RES       = 240,
    parameter int          SRC_TIMEOUT = 64,
    parameter logic [15:0] FILL_COLOR  = 16'h0000
) (
    input  logic        clk_16MHz,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic        stop,
    input  logic        clr_underrun,
    output logic        active,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        underrun,
    output logic        src_req,
    output logic [8:0]  src_x,
    output logic [7:0]  src_y,
    input  logic        src_valid,
    input  logic [15:0] src_data,
    output logic        reset_cursor,
    output logic [15:0] pix_data,
    output logic        pix_clk,
    input  logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        CURSOR,
        CURSOR_WAIT,
        FETCH,
        SEND,
        SEND_WAIT,
        FRAME_END
    } state_t;

    localparam logic [8:0] X_LAST = 9'(H_RES - 1);
    localparam logic [7:0] Y_LAST = 8'(V_RES - 1);
    localparam int         TW     = (SRC_TIMEOUT > 1) ? $clog2(SRC_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SRC_TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic          stop_pending;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          last_pixel;

    logic active_nxt;
    logic src_req_nxt;
    logic reset_cursor_nxt;
    logic pix_clk_nxt;
    logic frame_done_nxt;

    // A zero SRC_TIMEOUT disables substitution entirely.
    assign timeout    = (SRC_TIMEOUT != 0) && (state == FETCH) && !src_valid && (tcnt == T_LAST);
    assign last_pixel = (src_x == X_LAST) && (src_y == Y_LAST);

    always_ff @(posedge clk_16MHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (start) state_nxt = WAIT_RDY;
            WAIT_RDY:    if (!busy) state_nxt = CURSOR;
            CURSOR:      if (reset_cursor && busy) state_nxt = CURSOR_WAIT;
            CURSOR_WAIT: if (!busy) state_nxt = FETCH;
            FETCH:       if (src_valid || timeout) state_nxt = SEND;
            SEND:        if (pix_clk && busy) state_nxt = SEND_WAIT;
            SEND_WAIT: begin
                if (!busy) state_nxt = last_pixel ? FRAME_END : FETCH;
            end
            FRAME_END: begin
                // A stop arriving in this very cycle still ends the run.
                if (!(stop_pending || stop) && continuous) state_nxt = CURSOR;
                else                                       state_nxt = IDLE;
            end
            default:     state_nxt = IDLE;
        endcase
    end

    // Strobes only rise while the driver is idle and then hold until it reports busy.
    always_comb begin
        active_nxt       = (state_nxt != IDLE);
        src_req_nxt      = (state_nxt == FETCH);
        reset_cursor_nxt = (state_nxt == CURSOR) && (reset_cursor || !busy);
        pix_clk_nxt      = (state_nxt == SEND) && (pix_clk || !busy);
        frame_done_nxt   = (state_nxt == FRAME_END);
    end

    always_ff @(posedge clk_16MHz) begin
        if (reset) begin
            active       <= 1'b0;
            src_req      <= 1'b0;
            reset_cursor <= 1'b0;
            pix_clk      <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 16'd0;
            underrun     <= 1'b0;
            pix_data     <= 16'd0;
            src_x        <= 9'd0;
            src_y        <= 8'd0;
            stop_pending <= 1'b0;
            tcnt         <= '0;
        end else begin
            active       <= active_nxt;
            src_req      <= src_req_nxt;
            reset_cursor <= reset_cursor_nxt;
            pix_clk      <= pix_clk_nxt;
            frame_done   <= frame_done_nxt;

            if (frame_done_nxt) frame_count <= frame_count + 16'd1;

            if (state == IDLE) begin
                if (start) stop_pending <= stop;
            end else if (stop) begin
                stop_pending <= 1'b1;
            end

            if (state == IDLE && start) begin
                src_x <= 9'd0;
                src_y <= 8'd0;
            end else if (state == SEND_WAIT && !busy) begin
                if (src_x != X_LAST) begin
                    src_x <= src_x + 9'd1;
                end else begin
                    src_x <= 9'd0;
                    if (src_y != Y_LAST) src_y <= src_y + 8'd1;
                end
            end else if (state == FRAME_END) begin
                src_y <= 8'd0;
            end

            if (state == FETCH && !src_valid && !timeout) tcnt <= tcnt + 1'b1;
            else                                          tcnt <= '0;

            if (state == FETCH) begin
                if (src_valid)    pix_data <= src_data;
                else if (timeout) pix_data <= FILL_COLOR;
            end

            if (timeout)           underrun <= 1'b1;
            else if (clr_underrun) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ili9341_frame_sched.sv
// Bench for ili9341_frame_sched on a 4x3 screen: randomised source latency, driver busy
// lengths and pixel colours, checked against a raster-order expected pixel queue.
module tb_ili9341_frame_sched;

    localparam int          H    = 4;
    localparam int          V    = 3;
    localparam int          TO   = 8;
    localparam logic [15:0] FILL = 16'hBEEF;

    logic        clk_16MHz;
    logic        reset;
    logic        start;
    logic        continuous;
    logic        stop;
    logic        clr_underrun;
    logic        active;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        underrun;
    logic        src_req;
    logic [8:0]  src_x;
    logic [7:0]  src_y;
    logic        src_valid;
    logic [15:0] src_data;
    logic        reset_cursor;
    logic [15:0] pix_data;
    logic        pix_clk;
    logic        busy;

    logic        drv_busy;
    logic        init_busy;
    assign busy = drv_busy | init_busy;

    ili9341_frame_sched #(
        .H_RES(H), .V_RES(V), .SRC_TIMEOUT(TO), .FILL_COLOR(FILL)
    ) dut (
        .clk_16MHz(clk_16MHz), .reset(reset), .start(start), .continuous(continuous),
        .stop(stop), .clr_underrun(clr_underrun), .active(active), .frame_done(frame_done),
        .frame_count(frame_count), .underrun(underrun), .src_req(src_req), .src_x(src_x),
        .src_y(src_y), .src_valid(src_valid), .src_data(src_data),
        .reset_cursor(reset_cursor), .pix_data(pix_data), .pix_clk(pix_clk), .busy(busy)
    );

    initial begin
        clk_16MHz = 1'b0;
        forever #5 clk_16MHz = ~clk_16MHz;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] salt = 16'h0000;
    int          lat_max = 0;
    int          lat = 0;
    int          wcnt = 0;
    bit          stall_en = 1'b0;
    int          stall_x = 0;
    int          stall_y = 0;
    int          stall_cycles = 0;
    int          ncursor = 0;
    int          npix = 0;
    int          ndone = 0;
    int          dcnt = 0;
    bit          in_pix = 1'b0;
    logic [15:0] held = 16'h0;
    logic        prev_pclk = 1'b0;
    logic        prev_rc = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream: raster order, pixel value (x<<8 | y) ^ salt, fill colour where stalled.
    task automatic push_frame(input bit with_stall);
        for (int yi = 0; yi < V; yi++) begin
            for (int xi = 0; xi < H; xi++) begin
                if (with_stall && xi == stall_x && yi == stall_y) exp_q.push_back(FILL);
                else exp_q.push_back({8'(xi), 8'(yi)} ^ salt);
            end
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        @(negedge clk_16MHz);
        start = s; stop = p; clr_underrun = c;
        @(negedge clk_16MHz);
        start = 1'b0; stop = 1'b0; clr_underrun = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (active && n < budget) begin
            @(negedge clk_16MHz);
            n++;
        end
        check({tag, "_idle_in_time"}, 32'(active), 32'd0);
    endtask

    // Pixel source: answers after a random latency, never answers at the stalled pixel.
    always @(negedge clk_16MHz) begin
        if (reset) begin
            src_valid = 1'b0;
            wcnt = 0;
        end else if (src_req) begin
            if (stall_en && 32'(src_x) == stall_x && 32'(src_y) == stall_y) begin
                src_valid = 1'b0;
                stall_cycles++;
            end else if (wcnt >= lat) begin
                src_valid = 1'b1;
                src_data  = {src_x[7:0], src_y} ^ salt;
            end else begin
                wcnt++;
            end
        end else begin
            src_valid = 1'b0;
            wcnt = 0;
            lat = $urandom_range(0, lat_max);
        end
    end

    // Driver model: accepts a strobe when idle, stays busy 1..3 cycles, shares the reset.
    always @(negedge clk_16MHz) begin
        if (reset) begin
            drv_busy  = 1'b0;
            dcnt      = 0;
            in_pix    = 1'b0;
            prev_pclk = 1'b0;
            prev_rc   = 1'b0;
        end else begin
            if (pix_clk && !prev_pclk)     check("pix_clk_rise_when_idle", 32'(drv_busy | init_busy), 32'd0);
            if (reset_cursor && !prev_rc)  check("cursor_rise_when_idle", 32'(drv_busy | init_busy), 32'd0);
            if (drv_busy) begin
                if (in_pix) check("pix_data_hold", 32'(pix_data), 32'(held));
                dcnt--;
                if (dcnt == 0) drv_busy = 1'b0;
            end else if (!init_busy && (pix_clk || reset_cursor)) begin
                check("strobe_exclusive", 32'(pix_clk & reset_cursor), 32'd0);
                drv_busy = 1'b1;
                dcnt = $urandom_range(1, 3);
                if (pix_clk) begin
                    in_pix = 1'b1;
                    held = pix_data;
                    npix++;
                    check("pix_expected_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
                end else begin
                    in_pix = 1'b0;
                    ncursor++;
                end
            end
            if (frame_done) ndone++;
            prev_pclk = pix_clk;
            prev_rc   = reset_cursor;
        end
    end

    initial begin
        int n;
        int strobe_seen;
        int c0, p0, d0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; clr_underrun = 1'b0;
        init_busy = 1'b0; drv_busy = 1'b0; src_valid = 1'b0; src_data = 16'h0;

        // Reset state
        repeat (3) @(negedge clk_16MHz);
        reset = 1'b0;
        @(negedge clk_16MHz);
        check("rst_active", 32'(active), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_src_req", 32'(src_req), 32'd0);
        check("rst_pix_clk", 32'(pix_clk), 32'd0);
        check("rst_reset_cursor", 32'(reset_cursor), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_src_xy", {15'd0, src_x, src_y}, 32'd0);

        // Driver held busy after start, then a single frame with a zero-latency {x,y} source
        salt = 16'h0000;
        lat_max = 0;
        push_frame(1'b0);
        init_busy = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        strobe_seen = 0;
        repeat (1000) begin
            @(negedge clk_16MHz);
            if (reset_cursor || pix_clk || src_req) strobe_seen++;
        end
        check("init_no_strobe", 32'(strobe_seen), 32'd0);
        check("init_active", 32'(active), 32'd1);
        init_busy = 1'b0;
        @(negedge clk_16MHz);
        check("cursor_after_busy_fall", 32'(reset_cursor), 32'd1);
        wait_idle(2000, "single");
        check("single_frame_count", 32'(frame_count), 32'd1);
        check("single_done_pulses", 32'(ndone), 32'd1);
        check("single_cursor_handshakes", 32'(ncursor), 32'd1);
        check("single_pixels", 32'(npix), 32'd12);
        check("single_queue_drained", 32'(exp_q.size()), 32'd0);

        // Source silent at (2,1): fill colour after exactly TO request cycles, sticky underrun
        salt = 16'($urandom);
        lat_max = 3;
        stall_en = 1'b1; stall_x = 2; stall_y = 1; stall_cycles = 0;
        push_frame(1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle(3000, "timeout");
        check("timeout_req_cycles", 32'(stall_cycles), 32'(TO));
        check("timeout_frame_count", 32'(frame_count), 32'd2);
        check("timeout_pixels", 32'(npix), 32'd24);
        check("timeout_queue_drained", 32'(exp_q.size()), 32'd0);
        check("underrun_set", 32'(underrun), 32'd1);
        repeat (20) @(negedge clk_16MHz);
        check("underrun_sticky", 32'(underrun), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        check("underrun_cleared", 32'(underrun), 32'd0);
        stall_en = 1'b0;

        // Continuous refresh, stop pulsed in the middle of the third frame
        salt = 16'($urandom);
        lat_max = 5;
        c0 = ncursor; p0 = npix; d0 = ndone;
        push_frame(1'b0); push_frame(1'b0); push_frame(1'b0);
        continuous = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        n = 0;
        while (ndone < d0 + 2 && n < 5000) begin
            @(negedge clk_16MHz);
            n++;
        end
        check("cont_two_frames_reached", 32'(ndone), 32'(d0 + 2));
        repeat ($urandom_range(5, 40)) @(negedge clk_16MHz);
        pulse(1'b0, 1'b1, 1'b0);
        wait_idle(5000, "cont");
        check("cont_frame_count", 32'(frame_count), 32'd5);
        check("cont_done_pulses", 32'(ndone - d0), 32'd3);
        check("cont_cursor_handshakes", 32'(ncursor - c0), 32'd3);
        check("cont_pixels", 32'(npix - p0), 32'd36);
        check("cont_queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (50) @(negedge clk_16MHz);
        check("cont_no_fourth_cursor", 32'(ncursor - c0), 32'd3);
        check("cont_stays_idle", 32'(active), 32'd0);

        // start+stop together gives one frame; a start mid-frame is ignored
        salt = 16'($urandom);
        c0 = ncursor; p0 = npix;
        push_frame(1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        repeat (30) @(negedge clk_16MHz);
        check("oneshot_active_mid", 32'(active), 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle(3000, "oneshot");
        check("oneshot_frame_count", 32'(frame_count), 32'd6);
        check("oneshot_cursor_handshakes", 32'(ncursor - c0), 32'd1);
        check("oneshot_pixels", 32'(npix - p0), 32'd12);
        check("oneshot_queue_drained", 32'(exp_q.size()), 32'd0);
        continuous = 1'b0;

        // Reset held for 2 cycles while a pixel strobe is up, with underrun already set
        salt = 16'($urandom);
        lat_max = 2;
        stall_en = 1'b1; stall_x = 0; stall_y = 0;
        push_frame(1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!(pix_clk && underrun && src_x == 9'd1) && n < 3000) begin
            @(negedge clk_16MHz);
            n++;
        end
        check("midsend_reached", 32'(pix_clk & underrun), 32'd1);
        reset = 1'b1;
        @(negedge clk_16MHz);
        check("midrst_pix_clk", 32'(pix_clk), 32'd0);
        check("midrst_reset_cursor", 32'(reset_cursor), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        check("midrst_src_req", 32'(src_req), 32'd0);
        @(negedge clk_16MHz);
        reset = 1'b0;
        exp_q.delete();
        stall_en = 1'b0;

        // Fresh frame after reset starts with a cursor rewind
        salt = 16'($urandom);
        c0 = ncursor; p0 = npix;
        push_frame(1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_idle(3000, "after_reset");
        check("after_reset_frame_count", 32'(frame_count), 32'd1);
        check("after_reset_cursor", 32'(ncursor - c0), 32'd1);
        check("after_reset_pixels", 32'(npix - p0), 32'd12);
        check("after_reset_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
